// File: rtl/uart_tx_if.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | Module      : uart_tx_if                                                  |
// | Description : Request/config/serial-line bundle for the UART transmitter. |
// |               master = request source (drives byte, valid, config),       |
// |               slave  = uart_tx (drives TX_OUT and Busy).                  |
// | Signals     : P_DATA     byte to send                                     |
// |               Data_Valid send request                                     |
// |               PAR_EN     insert parity bit                                |
// |               PAR_TYP    0: even parity (^data), 1: odd parity (~^data)   |
// |               Prescale   clocks per bit (0 means 2**PRESCALE_WIDTH)       |
// |               TX_OUT     serial line, idle high                           |
// |               Busy       request would not be accepted                    |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
interface uart_tx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        output Prescale,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        input  Prescale,
        output TX_OUT,
        output Busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | Module      : uart_tx                                                     |
// | Description : Serial UART transmitter. Sends start bit, DATA_WIDTH data   |
// |               bits LSB first, optional parity bit and one stop bit.       |
// |               Every bit lasts the latched Prescale clocks (0 => 64 with   |
// |               the default PRESCALE_WIDTH). TX_OUT comes from a flop.      |
// | Ports       : clk    system clock, rising edge                            |
// |               rst    asynchronous reset, active LOW                       |
// |               io_tx  uart_tx_if.slave: P_DATA, Data_Valid, PAR_EN,        |
// |                      PAR_TYP, Prescale in; TX_OUT, Busy out               |
// | Config      : UART_TX_HOLD_REG_EN defined -> one-entry holding register;  |
// |               a request queued during a frame starts right after its      |
// |               stop bit with no idle gap, and Busy means "holding          |
// |               register full". Undefined -> single buffer, Busy covers     |
// |               the whole frame.                                            |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave io_tx
);

    localparam int                        IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]          c_LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]          c_IDX_ONE  = IDX_W'(1);
    localparam logic [PRESCALE_WIDTH-1:0] c_CNT_ONE  = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                    r_state;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_tx_out;
    logic                      r_busy;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    state_t                    w_state_nxt;
    logic [PRESCALE_WIDTH-1:0] w_cnt_nxt;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic                      w_tx_nxt;
    logic                      w_busy_nxt;
    logic                      w_bit_end;
    logic                      w_accept;
    logic                      w_start_in;

`ifdef UART_TX_HOLD_REG_EN
    logic                      r_hold_full;
    logic [DATA_WIDTH-1:0]     r_hold_data;
    logic                      r_hold_par_en;
    logic                      r_hold_par_typ;
    logic [PRESCALE_WIDTH-1:0] r_hold_prescale;
    logic                      w_start_hold;
    logic                      w_accept_hold;
`endif

    // The counter wraps naturally, so Prescale=0 gives a full 2**W period:
    // 0 - 1 = all ones is the last count.
    assign w_bit_end = (r_cnt == (r_prescale - c_CNT_ONE));
    assign w_accept  = io_tx.Data_Valid & ~r_busy;

`ifdef UART_TX_HOLD_REG_EN
    // A request arriving during a frame parks in the holding register, except
    // on the very last stop cycle, where it is launched directly instead so
    // the FSM never sits in IDLE with a queued request.
    assign w_accept_hold = w_accept && (r_state != S_IDLE) &&
                           !((r_state == S_STOP) && w_bit_end);
`endif

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_start_in   = 1'b0;
`ifdef UART_TX_HOLD_REG_EN
        w_start_hold = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_start_in  = 1'b1;
                end
            end
            S_START: begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_ONE;
                    end
                end
            end
            S_PARITY: begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
`ifdef UART_TX_HOLD_REG_EN
                    if (r_hold_full) begin
                        w_state_nxt  = S_START;
                        w_start_hold = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt  = S_START;
                        w_start_in   = 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line value for the next cycle. Data/parity use r_data, which was
    // loaded on entry to START and is therefore stable by the time the
    // FSM reaches DATA or PARITY.
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_data[w_idx_nxt];
            S_PARITY: w_tx_nxt = r_par_typ ? ~(^r_data) : (^r_data);
            default:  w_tx_nxt = 1'b1;
        endcase
    end

`ifdef UART_TX_HOLD_REG_EN
    assign w_busy_nxt = (r_hold_full | w_accept_hold) & ~w_start_hold;
`else
    assign w_busy_nxt = (w_state_nxt != S_IDLE);
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_tx_out <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Active-frame configuration, captured only when a frame is launched so
    // input changes mid-frame have no effect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_prescale <= '0;
        end else if (w_start_in) begin
            r_data     <= io_tx.P_DATA;
            r_par_en   <= io_tx.PAR_EN;
            r_par_typ  <= io_tx.PAR_TYP;
            r_prescale <= io_tx.Prescale;
        end
`ifdef UART_TX_HOLD_REG_EN
        else if (w_start_hold) begin
            r_data     <= r_hold_data;
            r_par_en   <= r_hold_par_en;
            r_par_typ  <= r_hold_par_typ;
            r_prescale <= r_hold_prescale;
        end
`endif
    end

`ifdef UART_TX_HOLD_REG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_full     <= 1'b0;
            r_hold_data     <= '0;
            r_hold_par_en   <= 1'b0;
            r_hold_par_typ  <= 1'b0;
            r_hold_prescale <= '0;
        end else if (w_accept_hold) begin
            r_hold_full     <= 1'b1;
            r_hold_data     <= io_tx.P_DATA;
            r_hold_par_en   <= io_tx.PAR_EN;
            r_hold_par_typ  <= io_tx.PAR_TYP;
            r_hold_prescale <= io_tx.Prescale;
        end else if (w_start_hold) begin
            r_hold_full     <= 1'b0;
        end
    end
`endif

    assign io_tx.TX_OUT = r_tx_out;
    assign io_tx.Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | Module      : tb_uart_tx                                                  |
// | Description : Directed, table-driven bench for uart_tx. Each vector is    |
// |               sent, the line and Busy are recorded once per clock and     |
// |               compared to hand-computed frames. Hand-written sequences    |
// |               cover async reset, dropped requests, back-to-back timing    |
// |               and (with UART_TX_HOLD_REG_EN) the holding register.        |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) u_if ();

    uart_tx #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .io_tx (u_if)
    );

    // frame bit k is the k-th bit on the line: bit 0 = start
    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [5:0]  prescale;
        logic [10:0] frame;
        int          nbits;
    } vec_t;

    vec_t vecs[6];
    logic tx_s [0:1023];
    logic bz_s [0:1023];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Request on one negedge, drop valid on the next (accept edge between).
    // Optionally scramble the inputs afterwards to prove they are ignored.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [5:0] ps, input bit scramble);
        @(negedge clk);
        u_if.P_DATA     = d;
        u_if.PAR_EN     = pe;
        u_if.PAR_TYP    = pt;
        u_if.Prescale   = ps;
        u_if.Data_Valid = 1'b1;
        @(negedge clk);
        u_if.Data_Valid = 1'b0;
        if (scramble) begin
            u_if.P_DATA   = ~d;
            u_if.PAR_EN   = ~pe;
            u_if.PAR_TYP  = ~pt;
            u_if.Prescale = 6'd5;
        end
    endtask

    // Sample n cycles starting at the negedge right after the accept edge;
    // optionally raise Data_Valid with pdata for plen cycles from cycle pat.
    task automatic record(input int n, input int pat, input logic [7:0] pdata, input int plen);
        for (int i = 0; i < n; i++) begin
            tx_s[i] = u_if.TX_OUT;
            bz_s[i] = u_if.Busy;
            if (i == pat) begin
                u_if.P_DATA     = pdata;
                u_if.Data_Valid = 1'b1;
            end
            if (i == pat + plen) u_if.Data_Valid = 1'b0;
            @(negedge clk);
        end
        u_if.Data_Valid = 1'b0;
    endtask

    // Byte sampled mid-bit from a frame whose start bit begins at cycle base.
    function automatic logic [7:0] decode(input int base, input int p);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = tx_s[base + (j + 1) * p + p / 2];
        return b;
    endfunction

    function automatic int count_ones(input int from, input int to, input bit busy_arr);
        int c = 0;
        for (int i = from; i < to; i++) begin
            if (busy_arr ? (bz_s[i] === 1'b1) : (tx_s[i] === 1'b0)) c++;
        end
        return c;
    endfunction

    task automatic check_vector(input int v);
        int   p, total, bad, bc, exp_busy;
        logic e, a;
        p     = (vecs[v].prescale == 6'd0) ? 64 : int'(vecs[v].prescale);
        total = vecs[v].nbits * p;
        for (int k = 0; k < vecs[v].nbits; k++) begin
            e   = vecs[v].frame[k];
            bad = -1;
            for (int c = k * p; c < (k + 1) * p; c++) if (tx_s[c] !== e) bad = c;
            a = (bad >= 0) ? tx_s[bad] : tx_s[k * p + p / 2];
            check($sformatf("v%0d bit%0d", v, k), {31'd0, a}, {31'd0, e});
        end
        bc = 0;
        while (bc < 1024 && bz_s[bc] === 1'b1) bc++;
`ifdef UART_TX_HOLD_REG_EN
        exp_busy = 0;
`else
        exp_busy = total;
`endif
        check($sformatf("v%0d busy_len", v), bc, exp_busy);
        check($sformatf("v%0d idle_tx", v), {31'd0, tx_s[total]}, 32'd1);
        check($sformatf("v%0d idle_busy", v), {31'd0, bz_s[total]}, 32'd0);
        check($sformatf("v%0d loopback", v), {24'd0, decode(0, p)}, {24'd0, vecs[v].data});
    endtask

    task automatic run_vector(input int v);
        int p;
        p = (vecs[v].prescale == 6'd0) ? 64 : int'(vecs[v].prescale);
        send(vecs[v].data, vecs[v].par_en, vecs[v].par_typ, vecs[v].prescale, 1'b1);
        record(vecs[v].nbits * p + 4, -1, 8'h00, 0);
        check_vector(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        //             data   pe    pt    P      frame     nbits
        vecs[0] = '{8'h45, 1'b0, 1'b0, 6'd32, 11'h28A, 10};
        vecs[1] = '{8'hAA, 1'b1, 1'b1, 6'd32, 11'h754, 11};
        vecs[2] = '{8'hA8, 1'b1, 1'b0, 6'd8,  11'h750, 11};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 6'd3,  11'h400, 11};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 6'd1,  11'h3FE, 10};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 6'd0,  11'h678, 11};

        rst             = 1'b0;
        u_if.P_DATA     = 8'h00;
        u_if.Data_Valid = 1'b0;
        u_if.PAR_EN     = 1'b0;
        u_if.PAR_TYP    = 1'b0;
        u_if.Prescale   = 6'd4;
        repeat (3) @(negedge clk);
        check("reset tx", {31'd0, u_if.TX_OUT}, 32'd1);
        check("reset busy", {31'd0, u_if.Busy}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post-reset tx", {31'd0, u_if.TX_OUT}, 32'd1);
        check("post-reset busy", {31'd0, u_if.Busy}, 32'd0);

        for (int v = 0; v < 6; v++) run_vector(v);

        // Asynchronous reset in the middle of a data bit that drives a 0.
        send(8'h00, 1'b0, 1'b0, 6'd8, 1'b0);
        repeat (20) @(negedge clk);
        check("mid-frame tx low", {31'd0, u_if.TX_OUT}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async reset tx", {31'd0, u_if.TX_OUT}, 32'd1);
        check("async reset busy", {31'd0, u_if.Busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        record(30, -1, 8'h00, 0);
        check("after reset no frame", count_ones(0, 30, 1'b0), 0);
        run_vector(2);

`ifdef UART_TX_HOLD_REG_EN
        // 8'h12 then 8'h34 five clocks later: back-to-back frames, Busy only
        // while 8'h34 sits in the holding register (cycles 6..39).
        send(8'h12, 1'b0, 1'b0, 6'd4, 1'b0);
        record(90, 5, 8'h34, 1);
        check("hold busy before", {31'd0, bz_s[5]}, 32'd0);
        check("hold busy set", {31'd0, bz_s[6]}, 32'd1);
        check("hold busy len", count_ones(0, 90, 1'b1), 34);
        check("hold stop bit", {31'd0, tx_s[39]}, 32'd1);
        check("hold no gap", {31'd0, tx_s[40]}, 32'd0);
        check("hold busy clear", {31'd0, bz_s[40]}, 32'd0);
        check("hold frame1", {24'd0, decode(0, 4)}, 32'h12);
        check("hold frame2", {24'd0, decode(40, 4)}, 32'h34);
        check("hold idle after", {31'd0, tx_s[80]}, 32'd1);
`else
        // Request while busy is dropped: one frame, then the line stays idle.
        send(8'h45, 1'b0, 1'b0, 6'd4, 1'b0);
        record(90, 10, 8'hFF, 1);
        check("drop busy len", count_ones(0, 90, 1'b1), 40);
        check("drop frame", {24'd0, decode(0, 4)}, 32'h45);
        check("drop idle tx", {31'd0, tx_s[40]}, 32'd1);
        check("drop no 2nd frame", count_ones(40, 90, 1'b0), 0);

        // Valid held high: next START one idle cycle after the stop period.
        send(8'h45, 1'b0, 1'b0, 6'd4, 1'b0);
        record(90, 0, 8'h45, 45);
        check("b2b idle tx", {31'd0, tx_s[40]}, 32'd1);
        check("b2b idle busy", {31'd0, bz_s[40]}, 32'd0);
        check("b2b restart tx", {31'd0, tx_s[41]}, 32'd0);
        check("b2b restart busy", {31'd0, bz_s[41]}, 32'd1);
        check("b2b frame2", {24'd0, decode(41, 4)}, 32'h45);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
